// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   path and the load/store data path. One transaction is outstanding at a
//   time: a requester is granted in IDLE, the arbiter waits in WAIT for the
//   memory acknowledge and routes the response back to the owner. A streak
//   counter keeps fetch from starving behind back-to-back data accesses, and
//   a timeout counter drops into a sticky ERR state if memory never answers.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-low reset
//   if_req/if_addr            fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata fetch grant and one-cycle response
//   d_req/d_we/d_addr/d_wdata data request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata    data grant and one-cycle response (store ack)
//   mem_en/mem_we/mem_addr/mem_wdata  memory command
//   mem_rvalid/mem_rdata      memory response
//   err                       sticky timeout error
module mem_port_arbiter #(
  parameter int A_WIDTH         = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [A_WIDTH-1:0]    if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [A_WIDTH-1:0]    d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [A_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t        state;
  logic          owner;     // 0 = fetch, 1 = data
  logic          owner_we;
  logic [SW-1:0] streak;
  logic [TW-1:0] tmo;

  logic fetch_wins;
  logic grant_f;
  logic grant_d;
  logic resp;

  // Data wins by default; fetch wins when data is idle or fetch has waited
  // through a full streak of data grants.
  assign fetch_wins = if_req && (!d_req || (streak == STREAK_MAX));
  assign grant_f    = (state == IDLE) && fetch_wins;
  assign grant_d    = (state == IDLE) && d_req && !fetch_wins;
  assign resp       = (state == WAIT) && mem_rvalid;

  // Grant and response paths are combinational so a request is accepted in
  // the same cycle and the memory response passes straight to the owner.
  always_comb begin
    if_gnt    = grant_f;
    d_gnt     = grant_d;
    mem_en    = grant_f || grant_d;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_f) begin
      mem_addr  = if_addr;
    end
    if_rvalid = resp && !owner;
    d_rvalid  = resp && owner;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !owner_we) ? mem_rdata : '0;
    err       = (state == ERR);
  end

  // Sequencer: latch the owner on a grant, wait for the acknowledge, and
  // fall into ERR after TIMEOUT silent WAIT cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      owner_we <= 1'b0;
      streak   <= '0;
      tmo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_f || grant_d) begin
            state    <= WAIT;
            owner    <= grant_d;
            owner_we <= grant_d && d_we;
            tmo      <= '0;
            if (grant_d && if_req)
              streak <= (streak == STREAK_MAX) ? streak : streak + SW'(1);
            else
              streak <= '0;
          end
        end
        WAIT: begin
          if (mem_rvalid)
            state <= IDLE;
          else if (tmo == TMO_LAST)
            state <= ERR;
          else
            tmo <= tmo + TW'(1);
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. The stimulus process pushes the
//   expected grant and response for every transaction into queues; a monitor
//   pops and compares whenever the DUT shows a grant or an rvalid. Direct
//   checks cover reset values, the timeout/err behaviour and ERR blocking.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic        mem_en, mem_we, err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    bit          port;   // 0 = fetch, 1 = data
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];

  mem_port_arbiter #(
    .A_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  // All outputs packed together for whole-port comparisons.
  wire [134:0] all_outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                           mem_en, mem_we, mem_addr, mem_wdata, err};

  task automatic checkOutput(input string name, input logic [134:0] act,
                             input logic [134:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dwe,
                               input logic [31:0] da, input logic [31:0] dwd,
                               input logic mrv, input logic [31:0] mrd);
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    mem_rvalid = mrv; mem_rdata = mrd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectGnt(input bit port, input logic [31:0] addr,
                           input logic we, input logic [31:0] wdata);
    gnt_t g;
    g.port = port; g.addr = addr; g.we = we; g.wdata = wdata;
    gnt_q.push_back(g);
  endtask

  task automatic expectRsp(input bit port, input logic [31:0] data);
    rsp_t r;
    r.port = port; r.data = data;
    rsp_q.push_back(r);
  endtask

  // Monitor: compares every grant and every response against the queues.
  initial begin
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
        if (gnt_q.size() == 0) begin
          checkOutput("unexpected_gnt", all_outs, '0);
        end else begin
          g = gnt_q.pop_front();
          checkOutput("grant",
            {31'd0, if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata},
            {31'd0, ~g.port, g.port, 1'b1, g.we, g.addr, g.wdata});
        end
      end
      if (if_rvalid === 1'b1 || d_rvalid === 1'b1) begin
        if (rsp_q.size() == 0) begin
          checkOutput("unexpected_rvalid", all_outs, '0);
        end else begin
          r = rsp_q.pop_front();
          checkOutput("response",
            {69'd0, if_rvalid, d_rvalid, if_rdata, d_rdata},
            {69'd0, ~r.port, r.port, r.port ? 32'd0 : r.data,
             r.port ? r.data : 32'd0});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Starvation pattern with both requesters held: 1 = data, 0 = fetch.
  logic [9:0] starve_pat = 10'b1111011110;

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    @(negedge clk);
    checkOutput("reset_outputs", all_outs, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single load, memory answers two cycles after the grant.
    applyStimulus(0, 0, 1, 0, 32'h100, 0, 0, 0);
    expectGnt(1, 32'h100, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    expectRsp(1, 32'hDEADBEEF);
    step();

    // Store: ack returns zero data even though memory drives rdata.
    applyStimulus(0, 0, 1, 1, 32'h200, 32'h55, 0, 0);
    expectGnt(1, 32'h200, 1, 32'h55);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
    expectRsp(1, 32'h0);
    step();

    // Fetch only.
    applyStimulus(1, 32'h0, 0, 0, 0, 32'h77, 0, 0);
    expectGnt(0, 32'h0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h00500513);
    expectRsp(0, 32'h00500513);
    step();

    // Starvation guard: both held, memory answers one cycle after each grant.
    applyStimulus(1, 32'h40, 1, 0, 32'h80, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (starve_pat[9 - i]) expectGnt(1, 32'h80, 0, 0);
      else                   expectGnt(0, 32'h40, 0, 0);
      mem_rvalid = 1'b0;
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1000 + i;
      expectRsp(starve_pat[9 - i], 32'h1000 + i);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset one cycle after the grant; the late acknowledge must be dropped.
    applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0);
    expectGnt(1, 32'h300, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1234);
    @(negedge clk);
    checkOutput("reset_in_wait", all_outs, '0);
    @(posedge clk); #1;
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
    expectGnt(0, 32'h500, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hABCD0001);
    expectRsp(0, 32'hABCD0001);
    step();

    // Timeout: 15 silent WAIT cycles, err visible from the next cycle.
    applyStimulus(0, 0, 1, 0, 32'h400, 0, 0, 0);
    expectGnt(1, 32'h400, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 14) checkOutput("err_before_timeout", {134'd0, err}, 135'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("err_at_timeout", {134'd0, err}, 135'd1);
    @(posedge clk); #1;

    // ERR blocks grants and responses until reset.
    applyStimulus(1, 32'h600, 1, 1, 32'h700, 32'h99, 1, 32'h5A5A5A5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("err_blocks", all_outs, 135'd1);
      @(posedge clk); #1;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("err_cleared", all_outs, '0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 1, 0, 32'h800, 0, 0, 0);
    expectGnt(1, 32'h800, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h13579BDF);
    expectRsp(1, 32'h13579BDF);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    checkOutput("grant_queue_drained", {103'd0, gnt_q.size()}, '0);
    checkOutput("response_queue_drained", {103'd0, rsp_q.size()}, '0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
